min_select_stream: RTL and testbench

- Sequential, parametrised successor to the two-input energy minimum selector used by the bidirectional search datapath.
- Accepts a stream of (energy, plot/direction) candidates over a valid/ready handshake, one group at a time, delimited by in_last.
- Per group, returns the minimum energy, its plot code, the candidate's index within the group, and the candidate count.
- Sits between the neighbour-expansion stage and the frontier update, replacing cascades of two-input selectors.

---
 rtl/min_select_stream_if.sv | 33 +++
 rtl/min_select_stream.sv | 155 +++++++++++++++
 tb/tb_min_select_stream.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/min_select_stream_if.sv
// Candidate stream and result bus for the streaming energy minimum selector.
// master = upstream/downstream side, slave = the selector itself.
interface min_select_stream_if #(
    parameter int ENE_W    = 8,
    parameter int PLOT_W   = 8,
    parameter int MAX_CAND = 16
);
    localparam int IDX_W = $clog2(MAX_CAND);
    localparam int CNT_W = $clog2(MAX_CAND + 1);

    logic              in_valid;
    logic              in_ready;
    logic [ENE_W-1:0]  in_ene;
    logic [PLOT_W-1:0] in_plot;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ENE_W-1:0]  out_ene;
    logic [PLOT_W-1:0] out_plot;
    logic [IDX_W-1:0]  out_idx;
    logic [CNT_W-1:0]  out_cnt;
    logic              out_trunc;

    modport master (
        output in_valid, in_ene, in_plot, in_last, out_ready,
        input  in_ready, out_valid, out_ene, out_plot, out_idx, out_cnt, out_trunc
    );

    modport slave (
        input  in_valid, in_ene, in_plot, in_last, out_ready,
        output in_ready, out_valid, out_ene, out_plot, out_idx, out_cnt, out_trunc
    );
endinterface

// File: rtl/min_select_stream.sv
// Streaming minimum-energy selector: folds a group of (energy, plot) candidates
// into the winner, its position and the group size, handed off over valid/ready.
module min_select_stream #(
    parameter int ENE_W    = 8,
    parameter int PLOT_W   = 8,
    parameter int MAX_CAND = 16,
    parameter int TIE_LAST = 1
) (
    input  logic                m_clock,
    input  logic                p_reset,
    input  logic                clear,
    min_select_stream_if.slave  bus
);
    localparam int IDX_W = $clog2(MAX_CAND);
    localparam int CNT_W = $clog2(MAX_CAND + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CAND);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_r, state_s;
    logic [ENE_W-1:0]   best_ene_r, best_ene_s;
    logic [PLOT_W-1:0]  best_plot_r, best_plot_s;
    logic [IDX_W-1:0]   best_idx_r, best_idx_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic [CNT_W-1:0]   cnt_inc_s;
    logic               trunc_r, trunc_s;
    logic               out_valid_r, out_valid_s;
    logic               in_ready_s;
    logic               accept_s;

    // Equal energies go to the newcomer only under the later-wins tie rule.
    function automatic logic cand_wins(input logic [ENE_W-1:0] cand_ene,
                                       input logic [ENE_W-1:0] held_ene);
        if (TIE_LAST != 0) begin
            cand_wins = (cand_ene <= held_ene);
        end else begin
            cand_wins = (cand_ene < held_ene);
        end
    endfunction

    // Input readiness: always open while collecting, follows the consumer while a result is held.
    always_comb begin
        in_ready_s = 1'b1;
        case (state_r)
            ST_DONE: in_ready_s = bus.out_ready;
            default: in_ready_s = 1'b1;
        endcase
    end

    assign accept_s = bus.in_valid & in_ready_s;

    // Next-state and winner-tracking logic.
    always_comb begin
        state_s     = state_r;
        best_ene_s  = best_ene_r;
        best_plot_s = best_plot_r;
        best_idx_s  = best_idx_r;
        cnt_s       = cnt_r;
        trunc_s     = trunc_r;
        cnt_inc_s   = cnt_r + CNT_W'(1);
        if (clear) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        best_ene_s  = bus.in_ene;
                        best_plot_s = bus.in_plot;
                        best_idx_s  = {IDX_W{1'b0}};
                        cnt_s       = CNT_W'(1);
                        trunc_s     = 1'b0;
                        state_s     = bus.in_last ? ST_DONE : ST_ACC;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_ACC: begin
                    if (accept_s) begin
                        if (cand_wins(bus.in_ene, best_ene_r)) begin
                            best_ene_s  = bus.in_ene;
                            best_plot_s = bus.in_plot;
                            best_idx_s  = cnt_r[IDX_W-1:0];
                        end else begin
                            best_idx_s  = best_idx_r;
                        end
                        cnt_s = cnt_inc_s;
                        // A full group closes on its own so the next beat opens a fresh one.
                        if (bus.in_last) begin
                            state_s = ST_DONE;
                            trunc_s = 1'b0;
                        end else if (cnt_inc_s == MAX_CNT) begin
                            state_s = ST_DONE;
                            trunc_s = 1'b1;
                        end else begin
                            state_s = ST_ACC;
                        end
                    end else begin
                        state_s = ST_ACC;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        if (accept_s) begin
                            best_ene_s  = bus.in_ene;
                            best_plot_s = bus.in_plot;
                            best_idx_s  = {IDX_W{1'b0}};
                            cnt_s       = CNT_W'(1);
                            trunc_s     = 1'b0;
                            state_s     = bus.in_last ? ST_DONE : ST_ACC;
                        end else begin
                            state_s = ST_IDLE;
                        end
                    end else begin
                        state_s = ST_DONE;
                    end
                end
                default: state_s = ST_IDLE;
            endcase
        end
        out_valid_s = (state_s == ST_DONE);
    end

    // State and result registers.
    always_ff @(posedge m_clock or posedge p_reset) begin
        if (p_reset) begin
            state_r     <= ST_IDLE;
            best_ene_r  <= {ENE_W{1'b0}};
            best_plot_r <= {PLOT_W{1'b0}};
            best_idx_r  <= {IDX_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            trunc_r     <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            best_ene_r  <= best_ene_s;
            best_plot_r <= best_plot_s;
            best_idx_r  <= best_idx_s;
            cnt_r       <= cnt_s;
            trunc_r     <= trunc_s;
            out_valid_r <= out_valid_s;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_ene   = best_ene_r;
    assign bus.out_plot  = best_plot_r;
    assign bus.out_idx   = best_idx_r;
    assign bus.out_cnt   = cnt_r;
    assign bus.out_trunc = trunc_r;
endmodule

// File: tb/tb_min_select_stream.sv
// Bench for min_select_stream: two instances (later-wins and earlier-wins ties)
// share one stimulus stream; a scoreboard holds the expected results per group.
module tb_min_select_stream;
    logic       m_clock;
    logic       p_reset;
    logic       clear;
    logic       in_valid;
    logic       in_last;
    logic       out_ready;
    logic [7:0] in_ene;
    logic [7:0] in_plot;

    typedef struct packed {
        logic [7:0] ene;
        logic [7:0] plot_a;
        logic [3:0] idx_a;
        logic [7:0] plot_b;
        logic [3:0] idx_b;
        logic [4:0] cnt;
        logic       trunc;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] g_ene  [32];
    logic [7:0] g_plot [32];
    logic       g_last [32];
    int         checks;
    int         errors;

    min_select_stream_if #(.ENE_W(8), .PLOT_W(8), .MAX_CAND(16)) ifa ();
    min_select_stream_if #(.ENE_W(8), .PLOT_W(8), .MAX_CAND(16)) ifb ();

    assign ifa.in_valid  = in_valid;
    assign ifa.in_ene    = in_ene;
    assign ifa.in_plot   = in_plot;
    assign ifa.in_last   = in_last;
    assign ifa.out_ready = out_ready;
    assign ifb.in_valid  = in_valid;
    assign ifb.in_ene    = in_ene;
    assign ifb.in_plot   = in_plot;
    assign ifb.in_last   = in_last;
    assign ifb.out_ready = out_ready;

    min_select_stream #(.ENE_W(8), .PLOT_W(8), .MAX_CAND(16), .TIE_LAST(1)) dut_a (
        .m_clock (m_clock),
        .p_reset (p_reset),
        .clear   (clear),
        .bus     (ifa)
    );

    min_select_stream #(.ENE_W(8), .PLOT_W(8), .MAX_CAND(16), .TIE_LAST(0)) dut_b (
        .m_clock (m_clock),
        .p_reset (p_reset),
        .clear   (clear),
        .bus     (ifb)
    );

    initial m_clock = 1'b0;
    always #5 m_clock = ~m_clock;

    // Reference: find the minimum value, then its first or last occurrence.
    function automatic int ref_idx(input int base, input int n, input bit tie_last);
        logic [7:0] minv;
        int         r;
        minv = g_ene[base];
        for (int i = 1; i < n; i++) if (g_ene[base+i] < minv) minv = g_ene[base+i];
        r = -1;
        for (int i = 0; i < n; i++) begin
            if (g_ene[base+i] == minv && (tie_last || r < 0)) r = i;
        end
        return r;
    endfunction

    task automatic push_exp(input int base, input int n, input bit trunc);
        exp_t e;
        int   ia;
        int   ib;
        ia       = ref_idx(base, n, 1'b1);
        ib       = ref_idx(base, n, 1'b0);
        e.ene    = g_ene[base+ia];
        e.plot_a = g_plot[base+ia];
        e.idx_a  = 4'(ia);
        e.plot_b = g_plot[base+ib];
        e.idx_b  = 4'(ib);
        e.cnt    = 5'(n);
        e.trunc  = trunc;
        sb_q.push_back(e);
    endtask

    task automatic test_reset();
        p_reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_ene = 8'h00; in_plot = 8'h00; out_ready = 1'b0;
        repeat (3) @(negedge m_clock);
        p_reset = 1'b0;
        @(negedge m_clock);
        checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b want=0", ifa.out_valid); end
        checks++; if (ifa.out_ene !== 8'h00) begin errors++; $display("FAIL reset_out_ene got=%h want=00", ifa.out_ene); end
        checks++; if (ifa.out_plot !== 8'h00) begin errors++; $display("FAIL reset_out_plot got=%h want=00", ifa.out_plot); end
        checks++; if (ifa.out_idx !== 4'd0) begin errors++; $display("FAIL reset_out_idx got=%0d want=0", ifa.out_idx); end
        checks++; if (ifa.out_cnt !== 5'd0) begin errors++; $display("FAIL reset_out_cnt got=%0d want=0", ifa.out_cnt); end
        checks++; if (ifa.out_trunc !== 1'b0) begin errors++; $display("FAIL reset_out_trunc got=%0b want=0", ifa.out_trunc); end
        checks++; if (ifa.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b want=1", ifa.in_ready); end
    endtask

    task automatic test_tie_rule();
        exp_t e;
        g_ene[0] = 8'd30; g_ene[1] = 8'd12; g_ene[2] = 8'd40; g_ene[3] = 8'd12;
        g_plot[0] = 8'h01; g_plot[1] = 8'h02; g_plot[2] = 8'h04; g_plot[3] = 8'h08;
        push_exp(0, 4, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge m_clock);
            in_valid = 1'b1; in_ene = g_ene[i]; in_plot = g_plot[i]; in_last = (i == 3);
            @(posedge m_clock);
        end
        @(negedge m_clock);
        in_valid = 1'b0; in_last = 1'b0;
        checks++; if (ifa.out_valid !== 1'b1) begin errors++; $display("FAIL tie_latency out_valid got=%0b want=1", ifa.out_valid); end
        e = sb_q.pop_front();
        checks++;
        if ({ifa.out_ene, ifa.out_plot, ifa.out_idx, ifa.out_cnt, ifa.out_trunc} !== {e.ene, e.plot_a, e.idx_a, e.cnt, e.trunc}) begin
            errors++;
            $display("FAIL tie_last1 got ene=%0d plot=%h idx=%0d cnt=%0d trunc=%0b want ene=%0d plot=%h idx=%0d cnt=%0d trunc=%0b",
                     ifa.out_ene, ifa.out_plot, ifa.out_idx, ifa.out_cnt, ifa.out_trunc, e.ene, e.plot_a, e.idx_a, e.cnt, e.trunc);
        end
        checks++;
        if ({ifb.out_ene, ifb.out_plot, ifb.out_idx} !== {e.ene, e.plot_b, e.idx_b}) begin
            errors++;
            $display("FAIL tie_last0 got ene=%0d plot=%h idx=%0d want ene=%0d plot=%h idx=%0d",
                     ifb.out_ene, ifb.out_plot, ifb.out_idx, e.ene, e.plot_b, e.idx_b);
        end
        @(negedge m_clock);
        checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL tie_handoff out_valid got=%0b want=0", ifa.out_valid); end
    endtask

    task automatic test_single_hold();
        exp_t e;
        g_ene[0] = 8'hFF; g_plot[0] = 8'h10;
        push_exp(0, 1, 1'b0);
        out_ready = 1'b0;
        @(negedge m_clock);
        in_valid = 1'b1; in_ene = g_ene[0]; in_plot = g_plot[0]; in_last = 1'b1;
        @(posedge m_clock);
        @(negedge m_clock);
        in_valid = 1'b0; in_last = 1'b0;
        e = sb_q[0];
        for (int c = 0; c < 5; c++) begin
            checks++; if (ifa.out_valid !== 1'b1) begin errors++; $display("FAIL hold_out_valid cycle=%0d got=%0b want=1", c, ifa.out_valid); end
            checks++; if (ifa.in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready cycle=%0d got=%0b want=0", c, ifa.in_ready); end
            checks++;
            if ({ifa.out_ene, ifa.out_plot, ifa.out_idx, ifa.out_cnt, ifa.out_trunc} !== {e.ene, e.plot_a, e.idx_a, e.cnt, e.trunc}) begin
                errors++;
                $display("FAIL hold_result cycle=%0d got ene=%h idx=%0d cnt=%0d want ene=%h idx=%0d cnt=%0d",
                         c, ifa.out_ene, ifa.out_idx, ifa.out_cnt, e.ene, e.idx_a, e.cnt);
            end
            @(negedge m_clock);
        end
        out_ready = 1'b1;
        @(negedge m_clock);
        void'(sb_q.pop_front());
        checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL hold_release out_valid got=%0b want=0", ifa.out_valid); end
    endtask

    // 17 beats counting down; the 17th carries in_last so its one-beat group closes.
    task automatic test_truncation();
        exp_t        e;
        int          nres;
        logic [31:0] seen;
        nres = 0; seen = 32'h0;
        for (int i = 0; i < 17; i++) begin
            g_ene[i] = 8'(16 - i); g_plot[i] = 8'(8'h20 + i); g_last[i] = (i == 16);
        end
        push_exp(0, 16, 1'b1);
        push_exp(16, 1, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i <= 17; i++) begin
            @(negedge m_clock);
            if (ifa.out_valid === 1'b1) begin
                seen[i] = 1'b1; nres++;
                e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
                checks++;
                if ({ifa.out_ene, ifa.out_plot, ifa.out_idx, ifa.out_cnt, ifa.out_trunc} !== {e.ene, e.plot_a, e.idx_a, e.cnt, e.trunc}) begin
                    errors++;
                    $display("FAIL trunc_result beat=%0d got ene=%0d idx=%0d cnt=%0d trunc=%0b want ene=%0d idx=%0d cnt=%0d trunc=%0b",
                             i, ifa.out_ene, ifa.out_idx, ifa.out_cnt, ifa.out_trunc, e.ene, e.idx_a, e.cnt, e.trunc);
                end
                checks++; if (ifa.in_ready !== 1'b1) begin errors++; $display("FAIL trunc_in_ready beat=%0d got=%0b want=1", i, ifa.in_ready); end
            end
            if (i < 17) begin
                in_valid = 1'b1; in_ene = g_ene[i]; in_plot = g_plot[i]; in_last = g_last[i];
                @(posedge m_clock);
            end else begin
                in_valid = 1'b0; in_last = 1'b0;
            end
        end
        checks++; if (nres != 2) begin errors++; $display("FAIL trunc_result_count got=%0d want=2", nres); end
        checks++; if (seen !== 32'h0003_0000) begin errors++; $display("FAIL trunc_timing got=%h want=00030000", seen); end
        @(negedge m_clock);
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        int          nres;
        logic [31:0] seen;
        nres = 0; seen = 32'h0;
        for (int i = 0; i < 6; i++) begin
            g_ene[i] = 8'($urandom_range(0, 255)); g_plot[i] = 8'($urandom_range(0, 255));
        end
        g_ene[4] = g_ene[3];
        g_last[0] = 1'b0; g_last[1] = 1'b1; g_last[2] = 1'b1;
        g_last[3] = 1'b0; g_last[4] = 1'b0; g_last[5] = 1'b1;
        push_exp(0, 2, 1'b0);
        push_exp(2, 1, 1'b0);
        push_exp(3, 3, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i <= 6; i++) begin
            @(negedge m_clock);
            if (ifa.out_valid === 1'b1) begin
                seen[i] = 1'b1; nres++;
                e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
                checks++;
                if ({ifa.out_ene, ifa.out_plot, ifa.out_idx, ifa.out_cnt} !== {e.ene, e.plot_a, e.idx_a, e.cnt}) begin
                    errors++;
                    $display("FAIL b2b_result_a beat=%0d got ene=%0d plot=%h idx=%0d cnt=%0d want ene=%0d plot=%h idx=%0d cnt=%0d",
                             i, ifa.out_ene, ifa.out_plot, ifa.out_idx, ifa.out_cnt, e.ene, e.plot_a, e.idx_a, e.cnt);
                end
                checks++;
                if ({ifb.out_ene, ifb.out_plot, ifb.out_idx} !== {e.ene, e.plot_b, e.idx_b}) begin
                    errors++;
                    $display("FAIL b2b_result_b beat=%0d got ene=%0d plot=%h idx=%0d want ene=%0d plot=%h idx=%0d",
                             i, ifb.out_ene, ifb.out_plot, ifb.out_idx, e.ene, e.plot_b, e.idx_b);
                end
            end
            if (i < 6) begin
                in_valid = 1'b1; in_ene = g_ene[i]; in_plot = g_plot[i]; in_last = g_last[i];
                @(posedge m_clock);
            end else begin
                in_valid = 1'b0; in_last = 1'b0;
            end
        end
        checks++; if (nres != 3) begin errors++; $display("FAIL b2b_result_count got=%0d want=3", nres); end
        checks++; if (seen !== 32'h0000_004C) begin errors++; $display("FAIL b2b_timing got=%h want=0000004c", seen); end
        @(negedge m_clock);
    endtask

    task automatic test_reset_clear();
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge m_clock);
            in_valid = 1'b1; in_ene = 8'(50 + 10 * i); in_plot = 8'h33; in_last = 1'b0;
            @(posedge m_clock);
        end
        #2 p_reset = 1'b1;
        #1;
        checks++; if (ifa.out_ene !== 8'h00) begin errors++; $display("FAIL async_reset_ene got=%h want=00", ifa.out_ene); end
        checks++; if (ifa.out_plot !== 8'h00) begin errors++; $display("FAIL async_reset_plot got=%h want=00", ifa.out_plot); end
        checks++; if (ifa.out_cnt !== 5'd0) begin errors++; $display("FAIL async_reset_cnt got=%0d want=0", ifa.out_cnt); end
        checks++; if (ifa.in_ready !== 1'b1) begin errors++; $display("FAIL async_reset_in_ready got=%0b want=1", ifa.in_ready); end
        @(negedge m_clock);
        p_reset = 1'b0; in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge m_clock);
        in_valid = 1'b1; in_ene = 8'd7; in_plot = 8'h44; in_last = 1'b1;
        @(posedge m_clock);
        @(negedge m_clock);
        in_valid = 1'b0; in_last = 1'b0;
        checks++; if (ifa.out_cnt !== 5'd1) begin errors++; $display("FAIL post_reset_cnt got=%0d want=1", ifa.out_cnt); end
        checks++; if (ifa.out_valid !== 1'b1) begin errors++; $display("FAIL pre_clear_valid got=%0b want=1", ifa.out_valid); end
        clear = 1'b1;
        @(negedge m_clock);
        clear = 1'b0;
        checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL clear_valid got=%0b want=0", ifa.out_valid); end
        checks++; if (ifa.in_ready !== 1'b1) begin errors++; $display("FAIL clear_in_ready got=%0b want=1", ifa.in_ready); end
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge m_clock);
            checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL clear_no_handoff cycle=%0d got=%0b want=0", c, ifa.out_valid); end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_tie_rule();
        test_single_hold();
        test_truncation();
        test_back_to_back();
        test_reset_clear();
        checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain got=%0d want=0", sb_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
